// File: rtl/m_ifetch_q.sv
// m_ifetch_q: instruction fetch with a small prefetch queue in front of ID.
// Issues one synchronous-read fetch per cycle while there is room for the
// returning word. The room check counts both queued words and the word still
// in flight. Returned words are queued with their PC and PC+4.
// Redirects flush everything. Halt only gates new issues.
module m_ifetch_q #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  input  logic                     w_halt,
  input  logic                     w_redirect,
  input  logic [31:0]              w_tpc,
  output logic                     w_imem_re,
  output logic [AW-1:0]            w_imem_addr,
  input  logic [31:0]              w_imem_dout,
  input  logic                     w_ready,
  output logic                     w_valid,
  output logic [31:0]              w_ir,
  output logic [31:0]              w_pc,
  output logic [31:0]              w_pc4,
  output logic [$clog2(DEPTH):0]   w_count
);

  localparam int              PW      = $clog2(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]     CNT_ONE = {{PW{1'b0}}, 1'b1};
  // occupancy limit, one bit wider than the count so count+inflight never wraps
  localparam logic [PW+1:0]   OCC_LIM = DEPTH[PW+1:0];

  logic [31:0]   r_fpc;
  logic          r_inf;
  logic [31:0]   r_infpc;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [PW:0]   r_cnt;

  logic [31:0]   q_ir  [DEPTH];
  logic [31:0]   q_pc  [DEPTH];
  logic [31:0]   q_pc4 [DEPTH];

  logic [PW+1:0] occ;
  logic          issue;
  logic          enq;
  logic          deq;
  logic          head_vld;

  // issue/enqueue/dequeue decisions; redirect overrides all of them
  always_comb begin
    occ      = {1'b0, r_cnt} + {{(PW+1){1'b0}}, r_inf};
    head_vld = (r_cnt != '0);
    issue    = ~w_rst & ~w_halt & ~w_redirect & (occ < OCC_LIM);
    enq      = r_inf & ~w_redirect;
    deq      = head_vld & w_ready & ~w_redirect;
  end

  assign w_imem_re   = issue;
  assign w_imem_addr = r_fpc[AW+1:2];

  // fetch PC: reset, redirect target (word aligned), or advance on issue
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_fpc <= RESET_PC;
    end else if (w_redirect) begin
      r_fpc <= {w_tpc[31:2], 2'b00};
    end else if (issue) begin
      r_fpc <= r_fpc + 32'd4;
    end
  end

  // in-flight tracking: exactly one word can be outstanding at a time
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_inf   <= 1'b0;
      r_infpc <= 32'h0;
    end else begin
      r_inf <= issue;
      if (issue) begin
        r_infpc <= r_fpc;
      end
    end
  end

  // queue pointers and occupancy; flush on reset or redirect
  always_ff @(posedge w_clk) begin
    if (w_rst || w_redirect) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (enq) begin
        r_wr <= r_wr + PTR_ONE;
      end
      if (deq) begin
        r_rd <= r_rd + PTR_ONE;
      end
      case ({enq, deq})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // queue storage; slot contents only matter while counted as occupied
  always_ff @(posedge w_clk) begin
    if (!w_rst && enq) begin
      q_ir[r_wr]  <= w_imem_dout;
      q_pc[r_wr]  <= r_infpc;
      q_pc4[r_wr] <= r_infpc + 32'd4;
    end
  end

  // head outputs come straight from the queue; zero whenever the queue is empty
  always_comb begin
    w_valid = head_vld;
    w_count = r_cnt;
    w_ir    = head_vld ? q_ir[r_rd]  : 32'h0;
    w_pc    = head_vld ? q_pc[r_rd]  : 32'h0;
    w_pc4   = head_vld ? q_pc4[r_rd] : 32'h0;
  end

endmodule

// File: tb/tb_m_ifetch_q.sv
// tb_m_ifetch_q: directed scenarios followed by random traffic. A queue-level
// reference model runs alongside the DUT. Every cycle its expected outputs are
// compared with the DUT, and each accepted head entry is popped from the
// expected queue and compared.
module tb_m_ifetch_q;

  localparam int DEPTH = 4;
  localparam int AW    = 12;

  logic          w_clk = 1'b0;
  logic          w_rst = 1'b1;
  logic          w_halt = 1'b0;
  logic          w_redirect = 1'b0;
  logic [31:0]   w_tpc = 32'h0;
  logic          w_imem_re;
  logic [AW-1:0] w_imem_addr;
  logic [31:0]   w_imem_dout = 32'h0;
  logic          w_ready = 1'b0;
  logic          w_valid;
  logic [31:0]   w_ir;
  logic [31:0]   w_pc;
  logic [31:0]   w_pc4;
  logic [2:0]    w_count;

  int n_chk  = 0;
  int n_fail = 0;

  m_ifetch_q #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_halt(w_halt), .w_redirect(w_redirect),
    .w_tpc(w_tpc), .w_imem_re(w_imem_re), .w_imem_addr(w_imem_addr),
    .w_imem_dout(w_imem_dout), .w_ready(w_ready), .w_valid(w_valid),
    .w_ir(w_ir), .w_pc(w_pc), .w_pc4(w_pc4), .w_count(w_count)
  );

  always #5 w_clk = ~w_clk;

  // instruction memory: word k holds 0x1000_0000 + k, one-cycle read latency
  always @(posedge w_clk) begin
    if (w_imem_re) w_imem_dout <= 32'h1000_0000 + {20'h0, w_imem_addr};
  end

  function automatic logic [31:0] memword(input logic [31:0] pc);
    return 32'h1000_0000 + {20'h0, pc[13:2]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s timed out at %0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_fpc = 32'h0;
  bit          m_inf = 1'b0;
  logic [31:0] m_infpc = 32'h0;
  logic [31:0] m_q[$];
  bit          armed = 1'b0;
  int          sz;
  bit          ev;
  bit          e_re;
  logic [31:0] hpc;

  // compare at the falling edge, then advance the model to the next rising edge
  always @(negedge w_clk) begin
    sz   = m_q.size();
    ev   = (sz != 0);
    hpc  = ev ? m_q[0] : 32'h0;
    e_re = !w_rst && !w_halt && !w_redirect && (sz + int'(m_inf) < DEPTH);
    if (armed) begin
      chk("valid",     {31'h0, w_valid},   {31'h0, ev});
      chk("count",     {29'h0, w_count},   sz);
      chk("imem_re",   {31'h0, w_imem_re}, {31'h0, e_re});
      chk("imem_addr", {20'h0, w_imem_addr}, {20'h0, m_fpc[13:2]});
      chk("head_pc",   w_pc,  hpc);
      chk("head_pc4",  w_pc4, ev ? hpc + 32'd4 : 32'h0);
      chk("head_ir",   w_ir,  ev ? memword(hpc) : 32'h0);
    end
    if (w_rst) begin
      m_q.delete();
      m_inf = 1'b0;
      m_fpc = 32'h0;
    end else if (w_redirect) begin
      m_q.delete();
      m_inf = 1'b0;
      m_fpc = {w_tpc[31:2], 2'b00};
    end else begin
      if (ev && w_ready) begin
        hpc = m_q.pop_front();
        if (armed) chk("deq_ir", w_ir, memword(hpc));
      end
      if (m_inf) m_q.push_back(m_infpc);
      if (e_re) begin
        m_inf   = 1'b1;
        m_infpc = m_fpc;
        m_fpc   = m_fpc + 32'd4;
      end else begin
        m_inf = 1'b0;
      end
    end
    armed = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    cyc();
    w_rst = 1'b0;
  endtask

  int  n_re;
  bit  found;

  initial begin
    // stream from reset
    w_ready = 1'b1;
    cyc(); cyc();
    w_rst = 1'b0;
    #1;
    chk("first_issue_re", {31'h0, w_imem_re}, 32'h1);
    cyc(); cyc(); #1;
    chk("first_valid_pc", w_pc, 32'h0);
    chk("first_valid", {31'h0, w_valid}, 32'h1);
    repeat (16) cyc();

    // backpressure from reset
    w_ready = 1'b0;
    do_reset();
    n_re = 0;
    repeat (8) begin
      #1;
      n_re += int'(w_imem_re);
      cyc();
    end
    chk("bp_issues", n_re, DEPTH);
    #1;
    chk("bp_count", {29'h0, w_count}, DEPTH);
    w_ready = 1'b1;
    repeat (12) cyc();

    // redirect while streaming, head PC 0x20
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(); #1;
      if (w_valid && w_pc == 32'h20) found = 1'b1;
    end
    if (!found) timeout("wait_head_20");
    w_redirect = 1'b1;
    w_tpc      = 32'h103;
    cyc();
    w_redirect = 1'b0;
    #1;
    chk("redir_addr", {20'h0, w_imem_addr}, 32'h40);
    cyc(); cyc(); #1;
    chk("redir_valid_r3", {31'h0, w_valid}, 32'h1);
    chk("redir_pc_r3", w_pc, 32'h100);
    repeat (6) cyc();

    // redirect with a full queue and no acceptance
    w_ready = 1'b0;
    repeat (8) cyc();
    w_redirect = 1'b1;
    w_tpc      = 32'h200;
    cyc();
    w_redirect = 1'b0;
    #1;
    chk("full_redir_count", {29'h0, w_count}, 32'h0);
    w_ready = 1'b1;
    repeat (8) cyc();

    // halt when fetch reaches PC 0x30
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (w_imem_re && w_imem_addr == 12'd12) found = 1'b1;
      else cyc();
    end
    if (!found) timeout("wait_fetch_30");
    w_halt = 1'b1;
    #1;
    chk("halt_re_drop", {31'h0, w_imem_re}, 32'h0);
    repeat (6) cyc();
    #1;
    chk("halt_drained", {31'h0, w_valid}, 32'h0);
    w_halt = 1'b0;
    #1;
    chk("halt_resume_addr", {20'h0, w_imem_addr}, 32'd12);
    repeat (6) cyc();

    // reset in the middle of operation with a full queue
    w_ready = 1'b0;
    repeat (8) cyc();
    #1;
    chk("pre_rst_count", {29'h0, w_count}, DEPTH);
    do_reset();
    w_ready = 1'b1;
    #1;
    chk("rst_count", {29'h0, w_count}, 32'h0);
    chk("rst_pc", w_pc, 32'h0);
    chk("rst_re", {31'h0, w_imem_re}, 32'h1);
    cyc(); cyc(); #1;
    chk("rst_first_valid", {31'h0, w_valid}, 32'h1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc();
      w_rst      = ($urandom_range(0, 79) == 0);
      w_halt     = ($urandom_range(0, 7) == 0);
      w_redirect = ($urandom_range(0, 15) == 0);
      w_tpc      = {18'h0, 12'($urandom_range(0, 4095)), 2'($urandom)};
      w_ready    = ($urandom_range(0, 3) != 0);
    end
    cyc();
    w_rst = 1'b0; w_halt = 1'b0; w_redirect = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/m_ifetch_q.md
# m_ifetch_q

Instruction-fetch stage with a prefetch queue for the 5-stage pipelined processor. It sits directly upstream of the ID stage. It drives the synchronous-read instruction memory (one-cycle read latency), buffers the returned words with their PC and PC+4, and presents them to decode through a valid/ready handshake. Branch redirects from ID flush the queue, and a halt request stops further fetching.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- AW, 12: instruction-memory word-address width.
- RESET_PC, 32'h0: fetch PC loaded on reset.

- w_clk  in  1  clock; all state changes on the rising edge.
- w_rst  in  1  reset, synchronous, active-high.
- w_halt  in  1  stop issuing new fetches while high.
- w_redirect  in  1  branch taken; flush the queue and restart at w_tpc.
- w_tpc  in  32  redirect target; bits [1:0] ignored.
- w_imem_re  out  1  fetch issued this cycle.
- w_imem_addr  out  AW  word address, r_fpc[AW+1:2].
- w_imem_dout  in  32  memory data, valid the cycle after an issue.
- w_ready  in  1  decode accepts the head entry this cycle.
- w_valid  out  1  head entry present.
- w_ir  out  32  head instruction.
- w_pc  out  32  head PC.
- w_pc4  out  32  head PC+4.
- w_count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- State:
  - fetch PC r_fpc.
  - circular queue (rd/wr pointers, count).
  - one in-flight flag r_inf with its PC r_infpc.
- Issue rule: w_imem_re = ~w_rst & ~w_halt & ~w_redirect & (count + r_inf < DEPTH).
- On issue:
  - r_fpc <= r_fpc + 4 (32-bit wrap).
  - r_inf <= 1 and r_infpc <= r_fpc.
  - If nothing is issued, r_inf <= 0.
- Return: if r_inf and not w_redirect, enqueue {w_imem_dout, r_infpc, r_infpc+4} at the end of the return cycle.
- Dequeue happens when w_valid & w_ready.
- Simultaneous enqueue and dequeue leaves the count unchanged.
- Enqueue never overflows, because the issue rule reserves a slot for each in-flight word.
- Outputs w_valid, w_ir, w_pc, w_pc4 and w_count are driven directly from registered state, with no memory-to-decode bypass.
- Redirect has priority over every other event. In the redirect cycle:
  - The queue is emptied and the pointers are cleared.
  - An in-flight return is discarded.
  - Any w_ready dequeue is ignored.
  - No request is issued.
  - r_fpc <= {w_tpc[31:2],2'b00}.
- Halt:
  - No new issues while w_halt is high.
  - An in-flight return still enqueues.
  - The queue keeps draining to decode.
  - When halt drops, fetching resumes at r_fpc with no PC lost.
- Redirect during halt updates r_fpc and flushes the queue, but issues nothing.
- Reset (any cycle, including mid-fetch with a full queue), effective the next cycle:
  - r_fpc = RESET_PC.
  - count = 0 and pointers = 0.
  - r_inf = 0.
  - w_valid = 0, w_ir = 0, w_pc = 0, w_pc4 = 0, w_count = 0.
  - w_imem_re is 0 during the reset cycle.

## Timing
- Fetch-to-valid latency is 2 cycles: issue in cycle t, data returns in t+1, and the entry is visible at w_valid in t+2.
- Steady state with w_ready=1 gives 1 instruction per cycle. Occupancy is 1 and in-flight is 1, so no bubbles.
- Backpressure: with w_ready=0 the block issues exactly DEPTH requests and then holds w_imem_re=0.
- After redirect in cycle r:
  - In cycle r+1, w_valid=0 and w_imem_re=1 at w_tpc.
  - The first target instruction is valid in r+3.
- Decode must sample the head only when w_valid & w_ready.
- The head is stable while w_valid=1 and w_ready=0.

## Test plan
- Stream: memory word k = 32'h1000_0000+k; release reset; hold w_ready=1.
  - Required: w_valid first high in cycle 2.
  - Required: w_pc = 0,4,8,… each cycle, w_ir matches, w_pc4 = w_pc+4, no gaps.
- Backpressure: w_ready=0 from reset.
  - Required: exactly 4 cycles with w_imem_re=1 (addr 0..3), then w_count=4 and w_imem_re=0.
  - Then raise w_ready. Required: PCs 0,4,8,12,16,20 delivered in order, no duplicate or skipped PC, refill overlaps the drain.
- Redirect while streaming with head PC 0x20: pulse w_redirect with w_tpc=0x103 together with w_ready=1.
  - Required next cycle: w_valid=0, w_count=0, w_imem_addr=0x40.
  - Required: the next valid PC is 0x100, in r+3.
  - Required: the discarded return never appears.
- Redirect with a full queue and w_ready=0.
  - Required: queue cleared in one cycle; fetch resumes at the target.
- Halt at PC 0x30 with w_ready=1.
  - Required: w_imem_re drops the same cycle; the in-flight entry and the queue drain; w_valid stays 0 afterwards.
  - Release halt. Required: fetch resumes at the exact next unfetched PC.
- Mid-operation reset with w_count=4.
  - Required next cycle: all outputs 0, w_count=0.
  - Required: the first fetch after reset is at RESET_PC, valid 2 cycles later.
